// File: rtl/cache_mem_arbiter.sv
// Shares one main-memory port between icache and dcache.
// Round-robin grant, one transaction in flight, timeout abort.
//
// Ports:
//   clk, rst                 clock, sync active-high reset
//   ic_req/ic_addr           icache read request
//   ic_rdata/ic_ack          icache read data, done pulse
//   dc_req/dc_we/dc_addr     dcache request (we=1 write)
//   dc_wdata                 dcache write data
//   dc_rdata/dc_ack          dcache read data, done pulse
//   mem_req/mem_we           memory request, write enable
//   mem_addr/mem_wdata       memory address, write data
//   mem_rdata/mem_ready      memory read data, completion
//   bus_err                  set with ack on a timed-out transaction
module cache_mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ic_req,
  input  logic [ADDR_W-1:0] ic_addr,
  output logic [DATA_W-1:0] ic_rdata,
  output logic              ic_ack,
  input  logic              dc_req,
  input  logic              dc_we,
  input  logic [ADDR_W-1:0] dc_addr,
  input  logic [DATA_W-1:0] dc_wdata,
  output logic [DATA_W-1:0] dc_rdata,
  output logic              dc_ack,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              bus_err
);

  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] TMAX =
    CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_e;

  typedef enum logic {
    OWN_I,
    OWN_D
  } own_e;

  state_e            state_q, state_d;
  own_e              owner_q, owner_d;
  own_e              last_q, last_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              err_q, err_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] ic_rd_q, ic_rd_d;
  logic [DATA_W-1:0] dc_rd_q, dc_rd_d;
  logic              gnt;
  logic              gnt_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= OWN_I;
      last_q  <= OWN_I;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      ic_rd_q <= '0;
      dc_rd_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      ic_rd_q <= ic_rd_d;
      dc_rd_q <= dc_rd_d;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    ic_rd_d = ic_rd_q;
    dc_rd_d = dc_rd_q;
    gnt     = 1'b0;
    gnt_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        // Tie goes to whoever did not win last time.
        unique case (1'b1)
          ic_req & dc_req: begin
            gnt   = 1'b1;
            gnt_d = (last_q == OWN_I);
          end
          dc_req & ~ic_req: begin
            gnt   = 1'b1;
            gnt_d = 1'b1;
          end
          ic_req & ~dc_req: begin
            gnt   = 1'b1;
            gnt_d = 1'b0;
          end
          default: ;
        endcase
        if (gnt) begin
          owner_d = gnt_d ? OWN_D : OWN_I;
          last_d  = gnt_d ? OWN_D : OWN_I;
          req_d   = 1'b1;
          cnt_d   = '0;
          err_d   = 1'b0;
          state_d = WAIT;
          if (gnt_d) begin
            we_d    = dc_we;
            addr_d  = dc_addr;
            wdata_d = dc_wdata;
          end else begin
            we_d    = 1'b0;
            addr_d  = ic_addr;
            wdata_d = '0;
          end
        end
      end

      WAIT: begin
        if (mem_ready) begin
          req_d   = 1'b0;
          state_d = RESP;
          if (owner_q == OWN_I) begin
            ic_rd_d = mem_rdata;
          end else if (!we_q) begin
            dc_rd_d = mem_rdata;
          end
        end else if (cnt_q == TMAX) begin
          // No reply: abort and report via bus_err.
          req_d   = 1'b0;
          err_d   = 1'b1;
          state_d = RESP;
          if (owner_q == OWN_I) begin
            ic_rd_d = '0;
          end else begin
            dc_rd_d = '0;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      RESP: begin
        err_d   = 1'b0;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  assign ic_ack    = (state_q == RESP) &&
                     (owner_q == OWN_I);
  assign dc_ack    = (state_q == RESP) &&
                     (owner_q == OWN_D);
  assign bus_err   = (state_q == RESP) && err_q;
  assign ic_rdata  = ic_rd_q;
  assign dc_rdata  = dc_rd_q;
  assign mem_req   = req_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Bench for cache_mem_arbiter: directed table,
// hand sequences and random transactions.
module tb_cache_mem_arbiter;

  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        ic_req;
  logic [31:0] ic_addr;
  logic [31:0] ic_rdata;
  logic        ic_ack;
  logic        dc_req;
  logic        dc_we;
  logic [31:0] dc_addr;
  logic [31:0] dc_wdata;
  logic [31:0] dc_rdata;
  logic        dc_ack;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        bus_err;

  int nerr = 0;
  int nchk = 0;

  // transaction-level model state
  bit          m_last_d;
  logic [31:0] m_ic_rd;
  logic [31:0] m_dc_rd;

  always #5 clk = ~clk;

  cache_mem_arbiter #(
    .ADDR_W(32),
    .DATA_W(32),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .ic_req(ic_req),
    .ic_addr(ic_addr),
    .ic_rdata(ic_rdata),
    .ic_ack(ic_ack),
    .dc_req(dc_req),
    .dc_we(dc_we),
    .dc_addr(dc_addr),
    .dc_wdata(dc_wdata),
    .dc_rdata(dc_rdata),
    .dc_ack(dc_ack),
    .mem_req(mem_req),
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_ready(mem_ready),
    .bus_err(bus_err)
  );

  typedef struct {
    bit          ic;
    bit          dc;
    logic [31:0] ia;
    logic [31:0] da;
    bit          dwe;
    logic [31:0] dwd;
    int          waits;
    logic [31:0] rd;
    bit          exp_d;
    bit          exp_err;
    int          exp_cyc;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h",
               nm, act, exp);
    end
  endtask

  // Entered at a negedge with the arbiter idle.
  task automatic run_txn(
    input bit          ic,
    input bit          dc,
    input logic [31:0] ia,
    input logic [31:0] da,
    input bit          dwe,
    input logic [31:0] dwd,
    input int          waits,
    input logic [31:0] rd,
    input bit          exp_d,
    input bit          exp_err,
    input int          exp_cyc,
    input logic [31:0] exp_rd);
    logic [31:0] e_addr;
    logic [31:0] e_wd;
    bit          e_we;
    int          n;
    bit          frz_bad;
    bit          ack_bad;
    ic_req    = ic;
    dc_req    = dc;
    ic_addr   = ia;
    dc_addr   = da;
    dc_we     = dwe;
    dc_wdata  = dwd;
    mem_ready = 1'b0;
    e_addr = exp_d ? da : ia;
    e_we   = exp_d ? dwe : 1'b0;
    e_wd   = exp_d ? dwd : 32'h0;
    @(negedge clk);
    chk("mem_req_latency", {31'b0, mem_req}, 1);
    chk("mem_addr", mem_addr, e_addr);
    chk("mem_we", {31'b0, mem_we}, {31'b0, e_we});
    chk("mem_wdata", mem_wdata, e_wd);
    n = 0;
    frz_bad = 0;
    ack_bad = 0;
    while (mem_req === 1'b1 &&
           n < TIMEOUT + 4) begin
      n++;
      if (mem_addr !== e_addr ||
          mem_we !== e_we ||
          mem_wdata !== e_wd)
        frz_bad = 1;
      if (ic_ack !== 1'b0 || dc_ack !== 1'b0)
        ack_bad = 1;
      mem_ready = (n == waits + 1);
      mem_rdata = (n == waits + 1) ? rd : $urandom;
      @(negedge clk);
    end
    mem_ready = 1'($urandom_range(0, 1));
    mem_rdata = $urandom;
    chk("mem_req_cycles", n, exp_cyc);
    chk("mem_regs_frozen", {31'b0, frz_bad}, 0);
    chk("ack_during_wait", {31'b0, ack_bad}, 0);
    chk("ic_ack", {31'b0, ic_ack},
        {31'b0, !exp_d});
    chk("dc_ack", {31'b0, dc_ack},
        {31'b0, exp_d});
    chk("bus_err", {31'b0, bus_err},
        {31'b0, exp_err});
    if (exp_d) begin
      m_dc_rd = exp_rd;
      dc_req  = 1'b0;
    end else begin
      m_ic_rd = exp_rd;
      ic_req  = 1'b0;
    end
    chk("ic_rdata", ic_rdata, m_ic_rd);
    chk("dc_rdata", dc_rdata, m_dc_rd);
    m_last_d = exp_d;
    @(negedge clk);
    chk("acks_after_resp",
        {30'b0, ic_ack, dc_ack}, 0);
    chk("err_after_resp", {31'b0, bus_err}, 0);
    chk("mem_req_idle", {31'b0, mem_req}, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    bit          pi;
    bit          pd;
    bit          rdwe;
    bit          wd;
    bit          er;
    logic [31:0] ria;
    logic [31:0] rda;
    logic [31:0] rdwd;
    logic [31:0] rd;
    logic [31:0] erd;
    int          w;
    int          cyc;

    tbl[0] = '{1, 1, 32'h100, 32'h200, 0, 32'h0,
               0, 32'hA0A0_0001, 1, 0, 1, 32'hA0A0_0001};
    tbl[1] = '{1, 1, 32'h100, 32'h208, 0, 32'h0,
               1, 32'h1111_1111, 0, 0, 2, 32'h1111_1111};
    tbl[2] = '{1, 1, 32'h104, 32'h208, 0, 32'h0,
               2, 32'h2222_2222, 1, 0, 3, 32'h2222_2222};
    tbl[3] = '{1, 1, 32'h104, 32'h208, 0, 32'h0,
               0, 32'h3333_3333, 0, 0, 1, 32'h3333_3333};
    tbl[4] = '{1, 0, 32'h1004, 32'h0, 0, 32'h0,
               0, 32'hDEAD_BEEF, 0, 0, 1, 32'hDEAD_BEEF};
    tbl[5] = '{0, 1, 32'h0, 32'h2008, 1, 32'h1234_5678,
               3, 32'hFFFF_0000, 1, 0, 4, 32'h2222_2222};
    tbl[6] = '{1, 0, 32'h3000, 32'h0, 0, 32'h0,
               99, 32'h9999_9999, 0, 1, 16, 32'h0};
    tbl[7] = '{0, 1, 32'h0, 32'h4000, 0, 32'h0,
               1, 32'hCAFE_F00D, 1, 0, 2, 32'hCAFE_F00D};

    rst       = 1'b1;
    ic_req    = 1'b0;
    dc_req    = 1'b0;
    ic_addr   = '0;
    dc_addr   = '0;
    dc_we     = 1'b0;
    dc_wdata  = '0;
    mem_rdata = '0;
    mem_ready = 1'b0;
    m_last_d  = 0;
    m_ic_rd   = '0;
    m_dc_rd   = '0;
    repeat (2) @(negedge clk);
    chk("rst_acks", {30'b0, ic_ack, dc_ack}, 0);
    chk("rst_mem_req", {31'b0, mem_req}, 0);
    chk("rst_mem_we", {31'b0, mem_we}, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_bus_err", {31'b0, bus_err}, 0);
    chk("rst_ic_rdata", ic_rdata, 0);
    chk("rst_dc_rdata", dc_rdata, 0);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      run_txn(tbl[i].ic, tbl[i].dc,
              tbl[i].ia, tbl[i].da,
              tbl[i].dwe, tbl[i].dwd,
              tbl[i].waits, tbl[i].rd,
              tbl[i].exp_d, tbl[i].exp_err,
              tbl[i].exp_cyc, tbl[i].exp_rd);
    end

    // reset in the second wait cycle of a dcache read
    ic_req  = 1'b0;
    dc_req  = 1'b1;
    dc_we   = 1'b0;
    dc_addr = 32'h5000;
    mem_ready = 1'b0;
    @(negedge clk);
    chk("rstmid_req_w1", {31'b0, mem_req}, 1);
    @(negedge clk);
    chk("rstmid_req_w2", {31'b0, mem_req}, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("rstmid_mem_req", {31'b0, mem_req}, 0);
    chk("rstmid_acks", {30'b0, ic_ack, dc_ack}, 0);
    chk("rstmid_dc_rdata", dc_rdata, 0);
    chk("rstmid_ic_rdata", ic_rdata, 0);
    rst    = 1'b0;
    dc_req = 1'b0;
    m_last_d = 0;
    m_ic_rd  = '0;
    m_dc_rd  = '0;
    @(negedge clk);
    chk("rstmid_no_ack", {30'b0, ic_ack, dc_ack}, 0);
    chk("rstmid_idle", {31'b0, mem_req}, 0);
    run_txn(1, 1, 32'h6000, 32'h7000, 0, 32'h0,
            0, 32'h0000_0077, 1, 0, 1, 32'h0000_0077);
    run_txn(1, 0, 32'h6000, 32'h0, 0, 32'h0,
            1, 32'h0000_0066, 0, 0, 2, 32'h0000_0066);

    // mem_ready while idle must be ignored
    ic_req = 1'b0;
    dc_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      mem_ready = 1'b1;
      mem_rdata = $urandom;
      @(negedge clk);
      chk("idle_rdy_acks", {30'b0, ic_ack, dc_ack}, 0);
      chk("idle_rdy_req", {31'b0, mem_req}, 0);
    end
    mem_ready = 1'b0;
    chk("idle_rdy_ic_rdata", ic_rdata, m_ic_rd);
    chk("idle_rdy_dc_rdata", dc_rdata, m_dc_rd);

    // random traffic against the transaction model
    pi = 0;
    pd = 0;
    ria = '0;
    rda = '0;
    rdwe = 0;
    rdwd = '0;
    for (int it = 0; it < 150; it++) begin
      if (!pi && $urandom_range(0, 1) == 1) begin
        pi  = 1;
        ria = $urandom;
      end
      if (!pd && $urandom_range(0, 1) == 1) begin
        pd   = 1;
        rda  = $urandom;
        rdwe = 1'($urandom_range(0, 1));
        rdwd = $urandom;
      end
      if (!pi && !pd) begin
        pi  = 1;
        ria = $urandom;
      end
      wd = (pi && pd) ? !m_last_d : pd;
      if ($urandom_range(0, 9) == 0)
        w = TIMEOUT + int'($urandom_range(0, 3));
      else
        w = int'($urandom_range(0, 5));
      rd  = $urandom;
      er  = (w >= TIMEOUT);
      cyc = er ? TIMEOUT : w + 1;
      if (er)
        erd = '0;
      else if (wd && rdwe)
        erd = m_dc_rd;
      else
        erd = rd;
      run_txn(pi, pd, ria, rda, rdwe, rdwd,
              w, rd, wd, er, cyc, erd);
      if (wd)
        pd = 0;
      else
        pi = 0;
    end

    $display("Result: errors=%0d of %0d checks",
             nerr, nchk);
    $finish;
  end

endmodule
